run_ctrl: RTL and testbench
===========================

# run_ctrl

Processor run-control stage directly downstream of `clk_divider`. It converts the divider's `clk_enable` phase signal into single-cycle CPU step pulses and holds the core in reset for a programmable number of divider periods after system reset. It also provides run, halt and single-step control from debug or button requests, and keeps a retired-step counter. Its `cpu_step` output is the sole advance enable for the RV32I core datapath.

## Interface
- `RESET_TICKS`, 2: divider ticks for which `cpu_rst` is held after `reset` drops; must be ≥1.
- `AUTO_RUN`, 1: 1 = enter RUN after reset hold; 0 = enter HALT.
- `CNT_W`, 32: width of `step_count`.
- `clk` input 1: system clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `clk_enable` input 1: level from `clk_divider`, 4 cycles high and 4 cycles low.
- `run_req` input 1: single-cycle pulse requesting RUN.
- `step_req` input 1: single-cycle pulse requesting one step.
- `halt_req` input 1: single-cycle pulse requesting HALT.
- `pc` input 32: current core PC, used for the breakpoint compare.
- `bp_addr` input 32: breakpoint address.
- `bp_valid` input 1: breakpoint armed.
- `cpu_step` output 1: one-cycle advance pulse to the core.
- `cpu_rst` output 1: core reset.
- `running` output 1: high when state is RUN.
- `halted` output 1: high when state is HALT.
- `step_count` output CNT_W: number of `cpu_step` pulses issued.
- `bp_hit` output 1: sticky breakpoint-hit flag.

## Operation
- Tick: `tick = clk_enable & ~clk_enable_q`, where `clk_enable_q` is registered and resets to 0. If `clk_enable` is high on the first cycle after reset, that cycle is a tick.
- States: RESET_HOLD, HALT, RUN, STEP_WAIT.
- RESET_HOLD:
  - `cpu_rst` = 1 and all requests are ignored.
  - A tick counter counts ticks. On the RESET_TICKS-th tick the block moves to RUN (AUTO_RUN=1) or HALT (AUTO_RUN=0).
  - No step is issued on that tick.
- HALT:
  - `run_req` moves to RUN.
  - `step_req` moves to STEP_WAIT.
- RUN: on each tick, issue `cpu_step` unless a halt or breakpoint applies.
- STEP_WAIT: on the next tick, issue exactly one `cpu_step`, then return to HALT.
- Request priority when requests coincide: `halt_req` > `step_req` > `run_req`.
  - `halt_req` in RUN or STEP_WAIT moves to HALT. If it coincides with a tick, that tick produces no step.
  - `step_req` in RUN and `run_req` in RUN are ignored.
  - `halt_req` in HALT has no effect.
- `step_count` increments by 1 with each `cpu_step` and wraps modulo 2^CNT_W.

## Timing
- Reset values: `cpu_step`=0, `cpu_rst`=1, `running`=0, `halted`=0, `step_count`=0, `bp_hit`=0. State resets to RESET_HOLD and the tick counter to 0.
- `reset` asserted in any state, mid-operation included, takes effect on the next edge. Any pending step is dropped.
- `cpu_step` is registered: it goes high in the cycle after the tick cycle, for exactly one cycle.
- Step spacing in RUN equals the divider period (8 cycles).
- `step_count` updates in the same edge that raises `cpu_step`.
- `cpu_rst` falls at the edge following the RESET_TICKS-th tick. The first step occurs at the next tick after that, one divider period later.
- A request arriving in the same cycle as a tick acts on that tick, e.g. `step_req` in HALT coinciding with a tick moves to STEP_WAIT and steps on the following tick.
- `running` and `halted` are registered and decoded from the state.

## Configuration
- Macro: `RUN_CTRL_BREAKPOINT_EN`.
- When defined, in RUN on a tick with `bp_valid` and `pc == bp_addr`:
  - No step is issued.
  - The state moves to HALT and `bp_hit` is set to 1.
- `bp_hit` clears when `run_req` or `step_req` is accepted from HALT.
- Leaving HALT also sets a skip-once flag. The first tick after leaving HALT ignores the compare, so execution can resume from the breakpoint. The flag clears on that step.
- When not defined: `pc`, `bp_addr` and `bp_valid` stay in the port list but are ignored, and `bp_hit` is constant 0.

## Structure
- `run_ctrl_pkg` holds:
  - the `run_state_t` enum (RESET_HOLD, HALT, RUN, STEP_WAIT);
  - the `RUN_CTRL_DIV_PERIOD = 8` constant used by the bench.
- Sub-module `rise_detect`: a registered rising-edge detector producing `tick`, with a synchronous reset to 0.
- Tick counter width: `$clog2(RESET_TICKS+1)`.

## Test plan
- Reset for 1 cycle with defaults, divider running → `cpu_rst` high through 2 ticks. `cpu_step` then pulses every 8 cycles, and `step_count`=3 after 3 pulses.
- `halt_req` in RUN in the same cycle as a tick → no `cpu_step`, `halted`=1 next cycle, `step_count` unchanged.
- AUTO_RUN=0, `step_req` in HALT → exactly one `cpu_step` at the next tick, then `halted`=1 and `step_count`=1. A second `step_req` gives `step_count`=2.
- With `RUN_CTRL_BREAKPOINT_EN`: `bp_valid`=1, `bp_addr`=0x10, `pc` reaching 0x10 in RUN → no step, `bp_hit`=1, `halted`=1. Then `run_req` → `bp_hit`=0, a step at the next tick even though `pc`=0x10, and RUN resumes.
- `reset` asserted mid-run for 1 cycle → next cycle `cpu_rst`=1, `step_count`=0, `cpu_step`=0 until the reset-hold sequence completes.
- CNT_W=4, run for 17 steps → `step_count` goes 15 → 0 → 1.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: run-control state encoding and divider period shared by design and bench.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        RESET_HOLD,
        HALT,
        RUN,
        STEP_WAIT
    } run_state_t;

    localparam int RUN_CTRL_DIV_PERIOD = 8;

endpackage

// File: rtl/run_ctrl_rise_detect.sv
// rise_detect: registered rising-edge detector turning the divider level into a one-cycle tick.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic tick
);

    logic din_q, din_d;

    always_comb din_d = din;

    always_ff @(posedge clk) begin
        if (reset) din_q <= 1'b0;
        else       din_q <= din_d;
    end

    assign tick = din & ~din_q;

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: turns divider ticks into CPU step pulses with reset hold, run/halt/step control.
// Optional breakpoint halting is enabled by defining RUN_CTRL_BREAKPOINT_EN.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int RESET_TICKS = 2,
    parameter bit AUTO_RUN    = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic [31:0]      pc,
    input  logic [31:0]      bp_addr,
    input  logic             bp_valid,
    output logic             cpu_step,
    output logic             cpu_rst,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] step_count,
    output logic             bp_hit
);

    localparam int TW = $clog2(RESET_TICKS + 1);

    logic             tick, bp_match;
    run_state_t       state_q, state_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             step_q, step_d, rst_q, rst_d;
    logic             running_q, running_d, halted_q, halted_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             bp_hit_q, bp_hit_d, skip_q, skip_d;

    rise_detect u_rise (
        .clk  (clk),
        .reset(reset),
        .din  (clk_enable),
        .tick (tick)
    );

`ifdef RUN_CTRL_BREAKPOINT_EN
    // skip_q lets the core step off the breakpoint it just stopped on
    assign bp_match = bp_valid && (pc == bp_addr) && !skip_q;
    assign bp_hit   = bp_hit_q;
`else
    logic unused_bp;
    assign bp_match  = 1'b0;
    assign bp_hit    = 1'b0;
    assign unused_bp = ^{pc, bp_addr, bp_valid, bp_hit_q, skip_q};
`endif

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        step_d   = 1'b0;
        bp_hit_d = bp_hit_q;
        skip_d   = skip_q;
        case (state_q)
            RESET_HOLD: if (tick) begin
                tcnt_d = tcnt_q + 1'b1;
                if (tcnt_q == TW'(RESET_TICKS - 1)) state_d = AUTO_RUN ? RUN : HALT;
            end
            HALT: if (!halt_req && (step_req || run_req)) begin
                state_d  = step_req ? STEP_WAIT : RUN;
                bp_hit_d = 1'b0;
                skip_d   = 1'b1;
            end
            RUN: if (halt_req) state_d = HALT;
            else if (tick && bp_match) begin
                state_d  = HALT;
                bp_hit_d = 1'b1;
            end else if (tick) begin
                step_d = 1'b1;
                skip_d = 1'b0;
            end
            STEP_WAIT: if (halt_req) state_d = HALT;
            else if (tick) begin
                step_d  = 1'b1;
                skip_d  = 1'b0;
                state_d = HALT;
            end
            default: state_d = RESET_HOLD;
        endcase
        count_d   = count_q + CNT_W'(step_d);
        rst_d     = state_d == RESET_HOLD;
        running_d = state_d == RUN;
        halted_d  = state_d == HALT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RESET_HOLD;
            tcnt_q    <= '0;
            step_q    <= 1'b0;
            rst_q     <= 1'b1;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
            count_q   <= '0;
            bp_hit_q  <= 1'b0;
            skip_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            step_q    <= step_d;
            rst_q     <= rst_d;
            running_q <= running_d;
            halted_q  <= halted_d;
            count_q   <= count_d;
            bp_hit_q  <= bp_hit_d;
            skip_q    <= skip_d;
        end
    end

    assign cpu_step   = step_q;
    assign cpu_rst    = rst_q;
    assign running    = running_q;
    assign halted     = halted_q;
    assign step_count = count_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: random requests and resets against a behavioural model, two parameterisations.
module tb_run_ctrl;
    import run_ctrl_pkg::*;

`ifdef RUN_CTRL_BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1, clk_enable = 1'b0;
    logic        run_req = 1'b0, step_req = 1'b0, halt_req = 1'b0, bp_valid = 1'b0;
    logic [31:0] pc = 32'h0, bp_addr = 32'h10;
    logic        step_a, rst_a, run_a, halt_a, bp_a;
    logic [31:0] cnt_a;
    logic        step_b, rst_b, run_b, halt_b, bp_b;
    logic [3:0]  cnt_b;
    int          n_cmp = 0, n_bad = 0, wraps = 0, steps_a = 0;

    always #5 clk = ~clk;

    run_ctrl dut_a (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
        .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
        .cpu_step(step_a), .cpu_rst(rst_a), .running(run_a), .halted(halt_a),
        .step_count(cnt_a), .bp_hit(bp_a)
    );

    run_ctrl #(.RESET_TICKS(1), .AUTO_RUN(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
        .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
        .cpu_step(step_b), .cpu_rst(rst_b), .running(run_b), .halted(halt_b),
        .step_count(cnt_b), .bp_hit(bp_b)
    );

    int         rt_p[2] = '{2, 1};
    bit         ar_p[2] = '{1'b1, 1'b0};
    int         w_p[2]  = '{32, 4};
    run_state_t mode[2];
    int         ticks[2];
    bit         ce_prev[2], skip[2], bp[2], e_step[2];
    longint     e_cnt[2];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(int i);
        bit tick;
        if (reset) begin
            mode[i] = RESET_HOLD; ticks[i] = 0; ce_prev[i] = 0; e_step[i] = 0;
            e_cnt[i] = 0; bp[i] = 0; skip[i] = 0;
            return;
        end
        tick = clk_enable && !ce_prev[i];
        ce_prev[i] = clk_enable;
        e_step[i] = 0;
        if (mode[i] == RESET_HOLD) begin
            if (tick) begin
                ticks[i]++;
                if (ticks[i] == rt_p[i]) mode[i] = ar_p[i] ? RUN : HALT;
            end
        end else if (mode[i] == HALT) begin
            if (!halt_req && (step_req || run_req)) begin
                mode[i] = step_req ? STEP_WAIT : RUN;
                bp[i] = 0;
                skip[i] = 1;
            end
        end else if (halt_req) begin
            mode[i] = HALT;
        end else if (tick) begin
            if (mode[i] == RUN && BP_EN && bp_valid && pc == bp_addr && !skip[i]) begin
                mode[i] = HALT;
                bp[i] = 1;
            end else begin
                e_step[i] = 1;
                skip[i] = 0;
                if (mode[i] == STEP_WAIT) mode[i] = HALT;
            end
        end
        e_cnt[i] = (e_cnt[i] + longint'(e_step[i])) & ((64'sd1 <<< w_p[i]) - 1);
    endtask

    task automatic check_all();
        chk("a_step",    32'(step_a), 32'(e_step[0]));
        chk("a_rst",     32'(rst_a),  32'(mode[0] == RESET_HOLD));
        chk("a_running", 32'(run_a),  32'(mode[0] == RUN));
        chk("a_halted",  32'(halt_a), 32'(mode[0] == HALT));
        chk("a_count",   cnt_a,       32'(e_cnt[0]));
        chk("a_bp_hit",  32'(bp_a),   32'(bp[0]));
        chk("b_step",    32'(step_b), 32'(e_step[1]));
        chk("b_rst",     32'(rst_b),  32'(mode[1] == RESET_HOLD));
        chk("b_running", 32'(run_b),  32'(mode[1] == RUN));
        chk("b_halted",  32'(halt_b), 32'(mode[1] == HALT));
        chk("b_count",   32'(cnt_b),  32'(e_cnt[1]));
        chk("b_bp_hit",  32'(bp_b),   32'(bp[1]));
    endtask

    initial begin
        int         ph;
        logic [3:0] prev_b;
        ph = int'($urandom_range(0, RUN_CTRL_DIV_PERIOD - 1));
        prev_b = '0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            reset      = (c < 2) || ($urandom_range(0, 799) == 0);
            clk_enable = ph < RUN_CTRL_DIV_PERIOD / 2;
            ph         = (ph + 1) % RUN_CTRL_DIV_PERIOD;
            run_req    = $urandom_range(0, 24) == 0;
            step_req   = $urandom_range(0, 29) == 0;
            halt_req   = $urandom_range(0, 149) == 0;
            bp_valid   = $urandom_range(0, 3) != 0;
            pc         = 32'(4 * $urandom_range(2, 6));
            @(posedge clk);
            model(0);
            model(1);
            #1;
            check_all();
            if (step_b && prev_b == 4'hf && cnt_b == 4'h0) wraps++;
            if (step_a) steps_a++;
            prev_b = cnt_b;
        end
        chk("b_count_wrapped", 32'(wraps > 0), 32'd1);
        chk("a_stepped", 32'(steps_a > 20), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
